// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped 8-bit timer/counter: widths, register map,
// clock-select encodings, flag indices and the prescaler divisor decode.
package timer_counter_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned D_ADDR_WIDTH = 7;
  localparam int unsigned OFF_WIDTH    = 3;
  localparam int unsigned CS_WIDTH     = 3;
  localparam int unsigned PRESC_WIDTH  = 10;
  localparam int unsigned FLAG_WIDTH   = 2;

  localparam logic [D_ADDR_WIDTH-1:0] BASE_ADDR = 7'h78;

  // Register offsets from BASE_ADDR
  localparam logic [OFF_WIDTH-1:0] TMR_TCCR  = 3'd0;
  localparam logic [OFF_WIDTH-1:0] TMR_TCNT  = 3'd1;
  localparam logic [OFF_WIDTH-1:0] TMR_OCR   = 3'd2;
  localparam logic [OFF_WIDTH-1:0] TMR_TIFR  = 3'd3;
  localparam logic [OFF_WIDTH-1:0] TMR_TIMSK = 3'd4;
  localparam logic [OFF_WIDTH-1:0] TMR_LAST  = TMR_TIMSK;

  // Clock-select encodings; 6 and 7 behave as stopped
  localparam logic [CS_WIDTH-1:0] TMR_CS_STOP    = 3'd0;
  localparam logic [CS_WIDTH-1:0] TMR_CS_DIV1    = 3'd1;
  localparam logic [CS_WIDTH-1:0] TMR_CS_DIV8    = 3'd2;
  localparam logic [CS_WIDTH-1:0] TMR_CS_DIV64   = 3'd3;
  localparam logic [CS_WIDTH-1:0] TMR_CS_DIV256  = 3'd4;
  localparam logic [CS_WIDTH-1:0] TMR_CS_DIV1024 = 3'd5;

  localparam int unsigned TMR_TOV = 0;
  localparam int unsigned TMR_OCF = 1;

  typedef struct packed {
    logic                ctc;
    logic [CS_WIDTH-1:0] cs;
  } tccr_t;

  typedef logic [FLAG_WIDTH-1:0] flags_t;

  // True for the clock selects that run the prescaler
  function automatic logic cs_running(input logic [CS_WIDTH-1:0] cs);
    return (cs >= TMR_CS_DIV1) && (cs <= TMR_CS_DIV1024);
  endfunction

  // Low-bit mask whose all-ones pattern marks a tick for the selected divisor
  function automatic logic [PRESC_WIDTH-1:0] presc_mask(input logic [CS_WIDTH-1:0] cs);
    logic [PRESC_WIDTH-1:0] m;
    case (cs)
      TMR_CS_STOP:    m = '0;
      TMR_CS_DIV1:    m = '0;
      TMR_CS_DIV8:    m = PRESC_WIDTH'(10'h007);
      TMR_CS_DIV64:   m = PRESC_WIDTH'(10'h03F);
      TMR_CS_DIV256:  m = PRESC_WIDTH'(10'h0FF);
      TMR_CS_DIV1024: m = PRESC_WIDTH'(10'h3FF);
      default:        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Data-bus control signals shared by the CPU, data SRAM and the timer.
interface timer_counter_if;
  import timer_counter_pkg::*;

  logic [D_ADDR_WIDTH-1:0] address;
  logic                    cs;
  logic                    we;
  logic                    oe;

  modport master (output address, cs, we, oe);
  modport slave  (input  address, cs, we, oe);

endinterface

// File: rtl/timer_prescaler.sv
// 10-bit free-running prescaler; tick is the combinational divisor strobe for the counter.
module timer_prescaler
  import timer_counter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [CS_WIDTH-1:0] cs_sel,
  input  logic                clear,
  output logic                tick
);

  logic [PRESC_WIDTH-1:0] cnt_q;
  logic [PRESC_WIDTH-1:0] cnt_d;
  logic [PRESC_WIDTH-1:0] mask_c;
  logic                   run_c;

  // Tick fires when the low log2(div) bits of the current count are all ones
  always_comb begin
    run_c  = cs_running(cs_sel);
    mask_c = presc_mask(cs_sel);
    cnt_d  = cnt_q;
    if (clear || !run_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_WIDTH'(1);
    end
    tick = run_c && ((cnt_q & mask_c) == mask_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Memory-mapped 8-bit timer/counter: bus decode, register file, compare/overflow
// logic and the tri-state read driver onto the shared data bus.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  timer_counter_if.slave        bus,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  irq
);

  tccr_t                 tccr_q,  tccr_d;
  logic [DATA_WIDTH-1:0] tcnt_q,  tcnt_d;
  logic [DATA_WIDTH-1:0] ocr_q,   ocr_d;
  flags_t                tifr_q,  tifr_d;
  flags_t                timsk_q, timsk_d;

  logic                  hit_c;
  logic                  wr_c;
  logic                  rd_c;
  logic [OFF_WIDTH-1:0]  off_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  presc_clear_c;
  logic                  tick_c;
  logic                  tov_set_c;
  logic                  ocf_set_c;

  assign wdata_c = data;

  // Address decode; a simultaneous we/oe is treated as a write
  always_comb begin
    hit_c = bus.cs && (bus.address >= BASE_ADDR) &&
            (bus.address <= (BASE_ADDR + D_ADDR_WIDTH'(TMR_LAST)));
    off_c = OFF_WIDTH'(bus.address - BASE_ADDR);
    wr_c  = hit_c && bus.we;
    rd_c  = hit_c && bus.oe && !bus.we;
    presc_clear_c = wr_c && (off_c == TMR_TCCR);
  end

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .cs_sel (tccr_q.cs),
    .clear  (presc_clear_c),
    .tick   (tick_c)
  );

  // Count/compare on tick; a CPU TCNT write overrides both the step and its flags
  always_comb begin
    tccr_d    = tccr_q;
    tcnt_d    = tcnt_q;
    ocr_d     = ocr_q;
    tifr_d    = tifr_q;
    timsk_d   = timsk_q;
    tov_set_c = 1'b0;
    ocf_set_c = 1'b0;

    if (tick_c) begin
      ocf_set_c = (tcnt_q == ocr_q);
      tov_set_c = !tccr_q.ctc && (tcnt_q == '1);
      if (ocf_set_c && tccr_q.ctc) begin
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + DATA_WIDTH'(1);
      end
    end

    if (wr_c) begin
      case (off_c)
        TMR_TCCR:  tccr_d = tccr_t'(wdata_c[$bits(tccr_t)-1:0]);
        TMR_TCNT: begin
          tcnt_d    = wdata_c;
          tov_set_c = 1'b0;
          ocf_set_c = 1'b0;
        end
        TMR_OCR:   ocr_d   = wdata_c;
        TMR_TIFR:  tifr_d  = tifr_q & ~wdata_c[FLAG_WIDTH-1:0];
        TMR_TIMSK: timsk_d = wdata_c[FLAG_WIDTH-1:0];
        default: ;
      endcase
    end

    // Hardware set has priority over a same-cycle write-1-to-clear
    tifr_d[TMR_TOV] = tifr_d[TMR_TOV] | tov_set_c;
    tifr_d[TMR_OCF] = tifr_d[TMR_OCF] | ocf_set_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tccr_q  <= '0;
      tcnt_q  <= '0;
      ocr_q   <= '0;
      tifr_q  <= '0;
      timsk_q <= '0;
    end else begin
      tccr_q  <= tccr_d;
      tcnt_q  <= tcnt_d;
      ocr_q   <= ocr_d;
      tifr_q  <= tifr_d;
      timsk_q <= timsk_d;
    end
  end

  // Read mux; unused register bits read as zero
  always_comb begin
    rdata_c = '0;
    case (off_c)
      TMR_TCCR:  rdata_c = DATA_WIDTH'(tccr_q);
      TMR_TCNT:  rdata_c = tcnt_q;
      TMR_OCR:   rdata_c = ocr_q;
      TMR_TIFR:  rdata_c = DATA_WIDTH'(tifr_q);
      TMR_TIMSK: rdata_c = DATA_WIDTH'(timsk_q);
      default:   rdata_c = '0;
    endcase
  end

  assign data = rd_c ? rdata_c : {DATA_WIDTH{1'bz}};
  assign irq  = |(tifr_q & timsk_q);

endmodule
